// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the MIPS retirement trace capture block.
// A record is one retired instruction, serialized as four 32-bit words.
package mips_trace_pkg;

   localparam int REC_WORDS = 4;
   localparam int IDX_W     = $clog2(REC_WORDS);

   typedef logic [IDX_W-1:0] idx_t;

   localparam idx_t W0 = 2'd0;
   localparam idx_t W1 = 2'd1;
   localparam idx_t W2 = 2'd2;
   localparam idx_t W3 = 2'd3;

   localparam int W2_MEM_BIT = 31;
   localparam int W2_REG_BIT = 30;
   localparam int W2_DST_HI  = 4;
   localparam int W2_DST_LO  = 0;

   // wb already holds the write-back value or the store address, chosen at capture
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        mem_write;
      logic        reg_write;
      logic [4:0]  dst;
      logic [31:0] wb;
   } trace_rec_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_t;

   function automatic logic [31:0] rec_word(input trace_rec_t r, input idx_t idx);
      logic [31:0] w;
      w = '0;
      case (idx)
         W0: w = r.pc;
         W1: w = r.instr;
         W2: begin
            w[W2_MEM_BIT]           = r.mem_write;
            w[W2_REG_BIT]           = r.reg_write;
            w[W2_DST_HI:W2_DST_LO]  = r.dst;
         end
         default: w = r.wb;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mips_trace_capture_if.sv
// Trace word stream: valid/ready handshake carrying 32-bit words with an
// end-of-record marker.
interface mips_trace_capture_if;

   logic        trace_valid;
   logic [31:0] trace_data;
   logic        trace_last;
   logic        trace_ready;

   modport master (
      output trace_valid,
      output trace_data,
      output trace_last,
      input  trace_ready
   );

   modport slave (
      input  trace_valid,
      input  trace_data,
      input  trace_last,
      output trace_ready
   );

endinterface

// File: rtl/mips_trace_fifo.sv
// Whole-record FIFO with wrap-bit pointers; the head record is read
// combinationally so the serializer can offer W0 the cycle it enters SEND.
module mips_trace_fifo
   import mips_trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  trace_rec_t              push_data,
   input  logic                    pop,
   output trace_rec_t              head,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   trace_rec_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr_q[AW-1:0]];
   assign level = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   // same slot, opposite lap: every entry is occupied
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/mips_trace_capture.sv
// Captures one record per enabled cycle into a record FIFO and serializes
// the head record as four words on a valid/ready trace stream.
module mips_trace_capture
   import mips_trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [31:0]             pc_out,
   input  logic [31:0]             instr,
   input  logic                    reg_write,
   input  logic [4:0]              reg_write_dst,
   input  logic [31:0]             reg_write_data,
   input  logic                    mem_write,
   input  logic [31:0]             alu_result,
   mips_trace_capture_if.master    trace,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow,
   output logic [15:0]             drop_count
);

   localparam int LW = $clog2(DEPTH) + 1;

   trace_rec_t  cap_rec;
   trace_rec_t  head_rec;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic        drop;
   logic        stay;

   ser_state_t  state_q, state_d;
   idx_t        idx_q, idx_d;
   logic        overflow_q, overflow_d;
   logic [15:0] drop_count_q, drop_count_d;

   always_comb begin
      cap_rec           = '0;
      cap_rec.pc        = pc_out;
      cap_rec.instr     = instr;
      cap_rec.mem_write = mem_write;
      cap_rec.reg_write = reg_write;
      cap_rec.dst       = reg_write_dst;
      cap_rec.wb        = reg_write ? reg_write_data : alu_result;
   end

   // A full FIFO still accepts a capture if the head leaves on the same edge.
   assign pop  = (state_q == ST_SEND) && (idx_q == W3) && trace.trace_ready;
   assign push = en && (!fifo_full || pop);
   assign drop = en && fifo_full && !pop;
   assign stay = (level > LW'(1)) || push;

   mips_trace_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (cap_rec),
      .pop       (pop),
      .head      (head_rec),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   always_comb begin
      state_d           = state_q;
      idx_d             = idx_q;
      trace.trace_valid = 1'b0;
      trace.trace_last  = 1'b0;
      trace.trace_data  = '0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_SEND;
         end
         ST_SEND: begin
            trace.trace_valid = 1'b1;
            trace.trace_last  = (idx_q == W3);
            trace.trace_data  = rec_word(head_rec, idx_q);
            if (trace.trace_ready) begin
               if (idx_q == W3) begin
                  idx_d   = W0;
                  state_d = stay ? ST_SEND : ST_IDLE;
               end else begin
                  idx_d = idx_q + idx_t'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      overflow_d   = overflow_q | drop;
      drop_count_d = drop_count_q;
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= W0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: doc/mips_trace_capture.md
MIPS_TRACE_CAPTURE -- requirements
Module: mips_trace_capture

Interface
REQ-001 Parameter DEPTH, 8, FIFO capacity in records; power of two, at least 2.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 en  in  1  capture enable; one record per clk edge while high.
REQ-005 pc_out  in  32  PC of the instruction executing this cycle.
REQ-006 instr  in  32  instruction word executing this cycle.
REQ-007 reg_write  in  1  register-file write strobe.
REQ-008 reg_write_dst  in  5  destination register index.
REQ-009 reg_write_data  in  32  register write-back value.
REQ-010 mem_write  in  1  data-memory write strobe.
REQ-011 alu_result  in  32  ALU output, which is the memory address on stores.
REQ-012 trace_valid  out  1  trace_data holds a valid word.
REQ-013 trace_data  out  32  serialized trace word.
REQ-014 trace_last  out  1  marks the final word of a record.
REQ-015 trace_ready  in  1  consumer accepts the word; a transfer occurs when trace_valid and trace_ready are both high.
REQ-016 level  out  clog2(DEPTH)+1  number of records in the FIFO.
REQ-017 overflow  out  1  sticky flag; set once any record has been dropped.
REQ-018 drop_count  out  16  count of dropped records; saturates at 16'hFFFF.

Function
REQ-019 Capture: the record is sampled at each rising edge where en=1, taking the input values present at that edge.
REQ-020 A record is 4 words sent in order:
- W0 = pc_out
- W1 = instr
- W2 = {mem_write, reg_write, 25'b0, reg_write_dst}
- W3 = reg_write_data when reg_write=1, otherwise alu_result
REQ-021 The FIFO holds whole records. A capture is pushed when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-022 Drop: a capture attempted while full with no same-edge pop is discarded. At that edge, overflow is set and drop_count increments (saturating).
REQ-023 The serializer FSM has two states:
- IDLE: trace_valid=0. Moves to SEND on an edge where level is nonzero.
- SEND: word index idx runs 0..3. trace_data = word idx of the FIFO head record; trace_valid=1.
REQ-024 In SEND, each transfer increments idx. A transfer at idx=3 pops the head record and resets idx to 0. The FSM stays in SEND if level after the pop is nonzero; otherwise it returns to IDLE.
REQ-025 trace_last=1 exactly when SEND and idx=3.
REQ-026 While trace_valid=1 and trace_ready=0, trace_data, trace_last and idx hold stable.
REQ-027 Latency: a record pushed at edge N has W0 offered no earlier than the cycle after edge N+1. Throughput is 1 word per cycle when trace_ready stays high.
REQ-028 level updates on the same edge as its push or pop. Simultaneous push and pop leave level unchanged.
REQ-029 en is ignored when it falls during SEND; the serializer drains the FIFO regardless of en.

Reset
REQ-030 While rst_n=0, all of the following are forced immediately:
- trace_valid=0, trace_last=0, trace_data=0
- level=0, overflow=0, drop_count=0
- FSM=IDLE, idx=0, FIFO pointers=0
REQ-031 A reset asserted mid-record abandons that record. After reset the serializer never resumes a partial record.
REQ-032 The first capture occurs at the first rising edge after rst_n deasserts with en=1.

Structure
REQ-033 Package mips_trace_pkg holds:
- record word count (4)
- word index constants W0..W3
- W2 flag bit positions (31 mem_write, 30 reg_write, 4:0 dst)
- the record struct typedef
REQ-034 Sub-module mips_trace_fifo is a synchronous DEPTH-entry record FIFO. It has push/pop, full/empty and level, with wrapping pointers one bit wider than the address.

Verification
REQ-035 Single record: en high for 1 cycle with pc_out=32'h0000_0004, instr=32'h2010_0005, reg_write=1, reg_write_dst=16, reg_write_data=5, trace_ready=1. Required output: words 0x4, 0x20100005, 0x40000010, 0x5, with trace_last on the 4th word.
REQ-036 Store: mem_write=1, reg_write=0, alu_result=32'h0000_0040. Required: W2=0x80000000 and W3=0x40.
REQ-037 Backpressure: trace_ready=0 for 5 cycles during W1. Required: trace_data stays 0x20100005 and does not advance. Once trace_ready=1, W2 follows on the next transfer.
REQ-038 Overflow: trace_ready=0 with en high for DEPTH+3 cycles. Required: level=8, overflow=1, drop_count=3. Draining then yields exactly 8 records in capture order.
REQ-039 Full with simultaneous pop: with the FIFO full, pulse en on the edge where W3 transfers. Required: no drop and level stays 8.
REQ-040 Reset mid-record: assert rst_n=0 during W2. Required: outputs go to 0 asynchronously. After release with FIFO empty, trace_valid stays 0.
